// File: rtl/sram_responder_if.sv
// Arbiter-side command/response bundle for sram_responder.
// master = arbiter, slave = responder.
interface sram_responder_if;
    logic [22:0] adr_i;
    logic [15:0] dat_i;
    logic [1:0]  dm_i;
    logic        rd_i;
    logic        wr_i;
    logic        enable_i;
    logic        valid_o;
    logic [15:0] dat_o;
    logic        busy_o;

    modport master (
        output adr_i, dat_i, dm_i, rd_i, wr_i, enable_i,
        input  valid_o, dat_o, busy_o
    );

    modport slave (
        input  adr_i, dat_i, dm_i, rd_i, wr_i, enable_i,
        output valid_o, dat_o, busy_o
    );
endinterface

// File: rtl/sram_responder.sv
// Single-access responder driving an asynchronous 16-bit SRAM with parameterised wait states.
// Optional statistics outputs (drop_cnt_o, err_o, acc_cnt_o) are enabled by SRAM_RESPONDER_STATS_EN.
module sram_responder #(
    parameter int ADDR_W  = 23,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    sram_responder_if.slave   bus,
    output logic [ADDR_W-1:0] sram_adr_o,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o
`ifdef SRAM_RESPONDER_STATS_EN
    ,
    output logic [7:0]        drop_cnt_o,
    output logic              err_o,
    output logic [15:0]       acc_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_RDWAIT  = 3'd2,
        S_WRPULSE = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cntr_q, cntr_d;
    logic              is_rd_q, is_rd_d;
    logic [1:0]        dm_q, dm_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [15:0]       wdat_q, wdat_d;
    logic [15:0]       rdat_q, rdat_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic              dq_oe_q, dq_oe_d;

    // Next-state, latched command and next values of the registered pins.
    always_comb begin
        state_d = state_q;
        cntr_d  = cntr_q;
        is_rd_d = is_rd_q;
        dm_d    = dm_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable_i && (bus.rd_i || bus.wr_i)) begin
                    is_rd_d = bus.rd_i;
                    dm_d    = bus.dm_i;
                    adr_d   = bus.adr_i[ADDR_W-1:0];
                    wdat_d  = bus.dat_i;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (is_rd_q) begin
                    cntr_d  = 4'(RD_WAIT - 1);
                    state_d = S_RDWAIT;
                end else begin
                    cntr_d  = 4'(WR_WAIT - 1);
                    state_d = S_WRPULSE;
                end
            end
            S_RDWAIT: begin
                if (cntr_q == 4'd0) begin
                    rdat_d  = sram_dq_i;
                    state_d = S_DONE;
                end else begin
                    cntr_d  = cntr_q - 4'd1;
                end
            end
            S_WRPULSE: begin
                if (cntr_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cntr_d  = cntr_q - 4'd1;
                end
            end
            S_HOLD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pins are decoded from the upcoming state so they line up with it once registered.
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            S_SETUP, S_RDWAIT, S_WRPULSE, S_HOLD: begin
                ce_n_d = 1'b0;
                if (is_rd_d) begin
                    oe_n_d = 1'b0;
                    ub_n_d = 1'b0;
                    lb_n_d = 1'b0;
                end else begin
                    dq_oe_d = 1'b1;
                    ub_n_d  = dm_d[1];
                    lb_n_d  = dm_d[0];
                    we_n_d  = (state_d != S_WRPULSE);
                end
            end
            default: begin
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cntr_q  <= 4'd0;
            is_rd_q <= 1'b0;
            dm_q    <= 2'b00;
            adr_q   <= '0;
            wdat_q  <= 16'h0000;
            rdat_q  <= 16'h0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            is_rd_q <= is_rd_d;
            dm_q    <= dm_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign bus.valid_o  = valid_q;
    assign bus.dat_o    = rdat_q;
    assign bus.busy_o   = busy_q;
    assign sram_adr_o   = adr_q;
    assign sram_dq_o    = wdat_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_ub_n_o  = ub_n_q;
    assign sram_lb_n_o  = lb_n_q;

`ifdef SRAM_RESPONDER_STATS_EN
    logic [7:0]  drop_q, drop_d;
    logic        err_q, err_d;
    logic [15:0] acc_q, acc_d;
    logic        drop_ev_s;

    // A strobe while busy is a dropped command; rd+wr together is flagged as a protocol error.
    always_comb begin
        drop_ev_s = bus.enable_i && busy_q;
        if (drop_ev_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
        err_d = err_q || drop_ev_s ||
                ((state_q == S_IDLE) && bus.enable_i && bus.rd_i && bus.wr_i);
        if (valid_d) begin
            acc_d = acc_q + 16'd1;
        end else begin
            acc_d = acc_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            drop_q <= 8'd0;
            err_q  <= 1'b0;
            acc_q  <= 16'd0;
        end else begin
            drop_q <= drop_d;
            err_q  <= err_d;
            acc_q  <= acc_d;
        end
    end

    assign drop_cnt_o = drop_q;
    assign err_o      = err_q;
    assign acc_cnt_o  = acc_q;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: vector table plus hand-written corner sequences,
// with a latency/read-data scoreboard per instance.
module tb_sram_responder;
    localparam int RDW0 = 2, WRW0 = 2, RDW1 = 1, WRW1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_responder_if bus0();
    sram_responder_if bus1();

    logic [22:0] adr0, adr1;
    logic [15:0] dqo0, dqo1, dqi0, dqi1;
    logic dqoe0, dqoe1, ce0, oe0, we0, ub0, lb0, ce1, oe1, we1, ub1, lb1;
`ifdef SRAM_RESPONDER_STATS_EN
    logic [7:0]  drop0, drop1;
    logic        err0, err1;
    logic [15:0] acc0, acc1;
`endif

    sram_responder #(.ADDR_W(23), .RD_WAIT(RDW0), .WR_WAIT(WRW0)) u0 (
        .clock_i(clk), .reset_i(rst), .bus(bus0),
        .sram_adr_o(adr0), .sram_dq_o(dqo0), .sram_dq_i(dqi0), .sram_dq_oe_o(dqoe0),
        .sram_ce_n_o(ce0), .sram_oe_n_o(oe0), .sram_we_n_o(we0),
        .sram_ub_n_o(ub0), .sram_lb_n_o(lb0)
`ifdef SRAM_RESPONDER_STATS_EN
        , .drop_cnt_o(drop0), .err_o(err0), .acc_cnt_o(acc0)
`endif
    );

    sram_responder #(.ADDR_W(23), .RD_WAIT(RDW1), .WR_WAIT(WRW1)) u1 (
        .clock_i(clk), .reset_i(rst), .bus(bus1),
        .sram_adr_o(adr1), .sram_dq_o(dqo1), .sram_dq_i(dqi1), .sram_dq_oe_o(dqoe1),
        .sram_ce_n_o(ce1), .sram_oe_n_o(oe1), .sram_we_n_o(we1),
        .sram_ub_n_o(ub1), .sram_lb_n_o(lb1)
`ifdef SRAM_RESPONDER_STATS_EN
        , .drop_cnt_o(drop1), .err_o(err1), .acc_cnt_o(acc1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model for u0: byte-laned write on the clock, read data presented mid-cycle.
    logic [15:0] mem [int];
    function automatic logic [15:0] mem_rd(input logic [22:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 16'h0000;
    endfunction
    always @(posedge clk) begin
        if (!ce0 && !we0 && dqoe0) begin
            logic [15:0] old;
            old = mem_rd(adr0);
            mem[int'(adr0)] = {ub0 ? old[15:8] : dqo0[15:8], lb0 ? old[7:0] : dqo0[7:0]};
        end
    end
    always @(negedge clk) dqi0 = mem_rd(adr0);
    assign dqi1 = adr1[15:0] ^ 16'hC3C3;

    // Strobe activity monitor for u0.
    int we_lo, oe_lo, dqoe_hi;
    logic [1:0] lanes;
    always @(negedge clk) begin
        if (!we0) we_lo++;
        if (!oe0) oe_lo++;
        if (dqoe0) dqoe_hi++;
        if (!we0 || !oe0) lanes = {ub0, lb0};
    end

    typedef struct {
        logic        is_rd;
        logic [15:0] dat;
        int          issue;
        int          lat;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always @(negedge clk) begin
        if (bus0.valid_o === 1'b1) begin
            chk("u0_valid_has_pending", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("u0_latency", 32'(cyc - e0.issue + 1), 32'(e0.lat));
                if (e0.is_rd) chk("u0_rd_data", 32'(bus0.dat_o), 32'(e0.dat));
            end
        end
        if (bus1.valid_o === 1'b1) begin
            chk("u1_valid_has_pending", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("u1_latency", 32'(cyc - e1.issue + 1), 32'(e1.lat));
                chk("u1_rd_data", 32'(bus1.dat_o), 32'(e1.dat));
            end
        end
    end

    task automatic issue(input int sel, input logic rd, input logic wr, input logic [22:0] a,
                         input logic [15:0] d, input logic [1:0] dm, input logic [15:0] exp_rd,
                         input logic push);
        exp_t e;
        @(posedge clk); #1;
        e.is_rd = rd;
        e.dat   = exp_rd;
        e.issue = cyc + 1;
        if (sel == 0) begin
            e.lat = rd ? RDW0 + 2 : WRW0 + 3;
            if (push) q0.push_back(e);
            bus0.rd_i = rd; bus0.wr_i = wr; bus0.adr_i = a; bus0.dat_i = d; bus0.dm_i = dm;
            bus0.enable_i = 1'b1;
        end else begin
            e.lat = rd ? RDW1 + 2 : WRW1 + 3;
            if (push) q1.push_back(e);
            bus1.rd_i = rd; bus1.wr_i = wr; bus1.adr_i = a; bus1.dat_i = d; bus1.dm_i = dm;
            bus1.enable_i = 1'b1;
        end
        @(posedge clk); #1;
        bus0.enable_i = 1'b0; bus0.rd_i = 1'b0; bus0.wr_i = 1'b0;
        bus1.enable_i = 1'b0; bus1.rd_i = 1'b0; bus1.wr_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0) && (n < 40)) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 32'(q0.size()), 32'd0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [22:0] adr;
        logic [15:0] dat;
        logic [1:0]  dm;
        logic [15:0] exp_dat;
    } vec_t;
    localparam int NV = 10;
    vec_t vt [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF};
        vt[1] = '{1'b0, 1'b1, 23'h7FFFFF, 16'h1234, 2'b01, 16'h0000};
        vt[2] = '{1'b1, 1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'h12CD};
        vt[3] = '{1'b0, 1'b1, 23'h000010, 16'h5A5A, 2'b00, 16'h0000};
        vt[4] = '{1'b0, 1'b1, 23'h000010, 16'hFFFF, 2'b11, 16'h0000};
        vt[5] = '{1'b1, 1'b0, 23'h000010, 16'h0000, 2'b00, 16'h5A5A};
        vt[6] = '{1'b0, 1'b1, 23'h000020, 16'h0102, 2'b10, 16'h0000};
        vt[7] = '{1'b1, 1'b0, 23'h000020, 16'h0000, 2'b00, 16'h0002};
        vt[8] = '{1'b1, 1'b1, 23'h7FFFFF, 16'h9999, 2'b00, 16'h12CD};
        vt[9] = '{1'b1, 1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'h12CD};

        mem[32'h000123] = 16'hBEEF;
        mem[32'h7FFFFF] = 16'hABCD;
        bus0.enable_i = 1'b0; bus0.rd_i = 1'b0; bus0.wr_i = 1'b0;
        bus0.adr_i = 23'h0; bus0.dat_i = 16'h0; bus0.dm_i = 2'b00;
        bus1.enable_i = 1'b0; bus1.rd_i = 1'b0; bus1.wr_i = 1'b0;
        bus1.adr_i = 23'h0; bus1.dat_i = 16'h0; bus1.dm_i = 2'b00;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({ce0, oe0, we0, ub0, lb0}), 32'h1F);
        chk("rst_valid_busy_oe", 32'({bus0.valid_o, bus0.busy_o, dqoe0}), 32'd0);
        chk("rst_dat_o", 32'(bus0.dat_o), 32'd0);
        chk("rst_adr_dq", 32'(adr0) | 32'(dqo0), 32'd0);
        chk("rst_u1_strobes", 32'({ce1, oe1, we1, ub1, lb1, dqoe1, bus1.busy_o}), 32'h7C);
        rst = 1'b0;
`ifdef SRAM_RESPONDER_STATS_EN
        chk("rst_stats", 32'({drop0, err0, acc0}), 32'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            we_lo = 0; oe_lo = 0; dqoe_hi = 0; lanes = 2'b11;
            issue(0, vt[i].rd, vt[i].wr, vt[i].adr, vt[i].dat, vt[i].dm, vt[i].exp_dat, 1'b1);
            chk("busy_during_access", 32'(bus0.busy_o), 32'd1);
            wait_done("vec_timeout");
            chk("we_low_cycles", 32'(we_lo), vt[i].rd ? 32'd0 : 32'(WRW0));
            chk("oe_low_cycles", 32'(oe_lo), vt[i].rd ? 32'(RDW0 + 1) : 32'd0);
            chk("dq_oe_cycles", 32'(dqoe_hi), vt[i].rd ? 32'd0 : 32'(WRW0 + 2));
            chk("byte_lanes", 32'(lanes), vt[i].rd ? 32'd0 : 32'(vt[i].dm));
        end
        chk("mem_masked_write", 32'(mem_rd(23'h7FFFFF)), 32'h12CD);
`ifdef SRAM_RESPONDER_STATS_EN
        chk("err_after_rdwr", 32'(err0), 32'd1);
        chk("acc_after_table", 32'(acc0), 32'(NV));
`endif

        // Second strobe two clocks into a read is ignored.
        issue(0, 1'b1, 1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF, 1'b1);
        issue(0, 1'b0, 1'b1, 23'h000040, 16'h7777, 2'b00, 16'h0000, 1'b0);
        wait_done("drop_timeout");
        repeat (8) @(posedge clk);
`ifdef SRAM_RESPONDER_STATS_EN
        chk("drop_cnt", 32'(drop0), 32'd1);
        chk("acc_after_drop", 32'(acc0), 32'(NV + 1));
`endif
        issue(0, 1'b1, 1'b0, 23'h000040, 16'h0000, 2'b00, 16'h0000, 1'b1);
        wait_done("dropped_write_read_timeout");

        // Reset while we_n is low aborts the access without valid_o.
        issue(0, 1'b0, 1'b1, 23'h000050, 16'h1111, 2'b00, 16'h0000, 1'b1);
        @(posedge clk); #1;
        chk("in_wrpulse_we_low", 32'(we0), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_strobes", 32'({ce0, oe0, we0, ub0, lb0}), 32'h1F);
        chk("abort_oe_valid_busy", 32'({dqoe0, bus0.valid_o, bus0.busy_o}), 32'd0);
`ifdef SRAM_RESPONDER_STATS_EN
        chk("abort_stats_clear", 32'({drop0, err0, acc0}), 32'd0);
`endif
        q0.delete();
        rst = 1'b0;
        repeat (8) @(posedge clk);
        issue(0, 1'b1, 1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF, 1'b1);
        wait_done("post_reset_read_timeout");
`ifdef SRAM_RESPONDER_STATS_EN
        chk("acc_post_reset", 32'(acc0), 32'd1);
`endif

        // Back-to-back reads on the RD_WAIT=1 instance: next strobe in the IDLE after DONE.
        for (int k = 0; k < 3; k++) begin
            logic [22:0] a;
            int n;
            a = 23'h000011 + 23'(k * 7);
            issue(1, 1'b1, 1'b0, a, 16'h0000, 2'b00, a[15:0] ^ 16'hC3C3, 1'b1);
            n = 0;
            while ((bus1.valid_o !== 1'b1) && (n < 20)) begin
                @(posedge clk); #1;
                n++;
            end
            chk("u1_valid_seen", 32'(bus1.valid_o), 32'd1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("u1_all_done", 32'(q1.size()), 32'd0);
`ifdef SRAM_RESPONDER_STATS_EN
        chk("u1_acc", 32'(acc1), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the arbiter output port. Accepts one-clock command strobes (enable_i with rd_i/wr_i, adr_i, dat_i, dm_i) and runs one access on an external asynchronous 16-bit SRAM.
- Returns valid_o when the access is complete, plus read data on dat_o.
- Sits between the memory arbiter and the FPGA SRAM pins. Wait states are set by parameters.

Parameters:
- ADDR_W, 23: SRAM word-address width; the low ADDR_W bits of adr_i are used.
- RD_WAIT, 2: read access cycles with oe_n low before data capture; must be ≥1.
- WR_WAIT, 2: cycles we_n is held low; must be ≥1.

Ports:
- clock_i  in  1  system clock, all logic on posedge
- reset_i  in  1  synchronous, active-high reset
- adr_i  in  23  word address from arbiter
- dat_i  in  16  write data
- dm_i  in  2  byte mask; bit1=upper byte, bit0=lower; 1 = masked (not written)
- rd_i  in  1  read request qualifier
- wr_i  in  1  write request qualifier
- enable_i  in  1  command strobe, one clock wide
- valid_o  out  1  access complete, one-clock pulse
- dat_o  out  16  read data, held until next read completes
- busy_o  out  1  high whenever state≠IDLE
- sram_adr_o  out  ADDR_W  SRAM address
- sram_dq_o  out  16  SRAM write data
- sram_dq_i  in  16  SRAM read data
- sram_dq_oe_o  out  1  tristate enable for sram_dq_o
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes
- sram_ub_n_o, sram_lb_n_o  out  1 each  active-low byte lanes

Behaviour:
- All outputs are registered.
- Reset values:
  - valid_o=0, busy_o=0, dat_o=0, sram_dq_oe_o=0, sram_dq_o=0, sram_adr_o=0.
  - All _n strobes = 1.
  - State = IDLE.
- Reset mid-access: the next edge forces the reset values. No valid_o is issued for the aborted access.
- States: IDLE, SETUP, RDWAIT, WRPULSE, HOLD, DONE. A 4-bit down-counter cntr is used.
- IDLE:
  - On enable_i & (rd_i|wr_i): latch adr/dat/dm and the operation, then go to SETUP.
  - rd_i&wr_i together: treated as a read.
  - enable_i with neither qualifier: ignored.
- SETUP (1 cycle):
  - Drive sram_adr_o and assert ce_n=0.
  - Read: oe_n=0 and ub_n=lb_n=0; set cntr=RD_WAIT-1; go to RDWAIT.
  - Write: dq_oe=1, dq_o=data, we_n=1, ub_n=dm[1], lb_n=dm[0]; set cntr=WR_WAIT-1; go to WRPULSE.
- RDWAIT:
  - Hold the read strobes.
  - When cntr==0: dat_o<=sram_dq_i (full word, dm ignored on reads) and go to DONE.
  - Otherwise decrement cntr.
- WRPULSE:
  - we_n=0.
  - When cntr==0: go to HOLD. Otherwise decrement cntr.
- HOLD (1 cycle): we_n=1 while address and data are still driven, giving hold time. Then go to DONE.
- DONE (1 cycle):
  - valid_o=1.
  - ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0.
  - Next state IDLE; valid_o returns to 0.
- Latency, counted from the edge that samples enable_i to the cycle with valid_o=1:
  - Read: RD_WAIT+2 clocks (4 at default).
  - Write: WR_WAIT+3 clocks (5 at default).
- Write with dm_i=2'b11: the full cycle still runs with both lanes high (no byte written), and valid_o still pulses.
- enable_i while busy_o=1: ignored with no queueing. The arbiter guarantees this does not happen.
- Back-to-back accesses: a new enable_i is accepted in IDLE on the cycle immediately after DONE.
- Address uses adr_i[ADDR_W-1:0]; higher bits are ignored, with no wrap detection.

Optional Feature:
- Macro SRAM_RESPONDER_STATS_EN.
- When defined, add three outputs:
  - drop_cnt_o[7:0]: increments on each enable_i seen while busy_o=1, saturating at 255.
  - err_o: sticky flag, set on any dropped enable or on an rd_i&wr_i command.
  - Both drop_cnt_o and err_o clear only on reset_i.
  - acc_cnt_o[15:0]: counts completed accesses, wrapping at 65535→0.
- When undefined, these ports and their logic are absent; core behaviour is identical.

Test Plan:
- Reset, then read adr=0x000123 with SRAM model returning 0xBEEF → valid_o high exactly 4 clocks after enable; dat_o=0xBEEF; oe_n low for 3 cycles (SETUP+2); we_n stays 1.
- Write adr=0x7FFFFF, dat=0x1234, dm=2'b01 → we_n low for 2 cycles; ub_n=0, lb_n=1; dq_oe high SETUP..HOLD; model upper byte=0x12, lower unchanged; valid_o 5 clocks after enable.
- Command with rd_i=wr_i=1 → read cycle only, we_n never low; err_o=1 under SRAM_RESPONDER_STATS_EN.
- Second enable issued 2 clocks into a read → ignored; one valid_o only; drop_cnt_o=1 under SRAM_RESPONDER_STATS_EN.
- Assert reset_i during WRPULSE → next edge has all strobes 1, dq_oe=0, valid_o never pulses; a fresh read afterwards completes normally.
- Two reads back-to-back (enable on the cycle after DONE), with RD_WAIT=1 → each valid_o 3 clocks after its enable; dat_o updates per access.
